// File: rtl/axi_ram_wr_if.sv
// AXI4 write-channel bundle (AW, W, B) shared by the write-side RAM model and its master.
interface axi_ram_wr_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
);
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_ram_wr.sv
// AXI4 write slave: one burst at a time, turned into single-beat word writes.
// Optional macro AXI_RAM_WR_WRAP_EN enables WRAP bursts; otherwise every WRAP burst answers SLVERR.
module axi_ram_wr #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                                        clk,
  input  logic                                        rst,
  axi_ram_wr_if.slave                                 s_axi,
  output logic                                        mem_wr_en,
  output logic [ADDR_WIDTH-$clog2(STRB_WIDTH)-1:0]    mem_wr_addr,
  output logic [DATA_WIDTH-1:0]                       mem_wr_data,
  output logic [STRB_WIDTH-1:0]                       mem_wr_strb
);

  localparam int          ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int          WADDR_W  = ADDR_WIDTH - ADDR_LSB;
  localparam logic [2:0]  MAX_SIZE = 3'(ADDR_LSB);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  aw_err_q, aw_err_d;
  logic                  err_q, err_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic [WADDR_W-1:0]    mem_wr_addr_q, mem_wr_addr_d;
  logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  logic [STRB_WIDTH-1:0] mem_wr_strb_q, mem_wr_strb_d;

  logic                  aw_hs_s;
  logic                  w_hs_s;
  logic                  last_s;
  logic                  aw_err_s;
  logic                  err_next_s;
  logic [ADDR_WIDTH-1:0] incr_sum_s;
  logic [ADDR_WIDTH-1:0] next_addr_s;

  assign aw_hs_s    = awready_q & s_axi.awvalid;
  assign w_hs_s     = wready_q & s_axi.wvalid;
  assign last_s     = (cnt_q == len_q);
  assign err_next_s = err_q | (s_axi.wlast != last_s);
  assign incr_sum_s = addr_q + (ADDR_WIDTH'(1'b1) << size_q);

`ifdef AXI_RAM_WR_WRAP_EN
  logic [ADDR_WIDTH-1:0] wrap_mask_s;
  assign wrap_mask_s = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1'b1)) << size_q) - ADDR_WIDTH'(1'b1);
`endif

  // Bursts rejected at AW: oversize beats, reserved burst type, illegal WRAP length.
  always_comb begin
    aw_err_s = 1'b0;
    if (s_axi.awsize > MAX_SIZE) begin
      aw_err_s = 1'b1;
    end else if (s_axi.awburst == 2'b11) begin
      aw_err_s = 1'b1;
    end else if (s_axi.awburst == 2'b10) begin
`ifdef AXI_RAM_WR_WRAP_EN
      aw_err_s = !(s_axi.awlen inside {8'd1, 8'd3, 8'd7, 8'd15});
`else
      aw_err_s = 1'b1;
`endif
    end else begin
      aw_err_s = 1'b0;
    end
  end

  // Address of the beat after the current one.
  always_comb begin
    next_addr_s = addr_q;
    case (burst_q)
      2'b00:   next_addr_s = addr_q;
      2'b01:   next_addr_s = incr_sum_s;
`ifdef AXI_RAM_WR_WRAP_EN
      2'b10:   next_addr_s = (addr_q & ~wrap_mask_s) | (incr_sum_s & wrap_mask_s);
`else
      2'b10:   next_addr_s = addr_q;
`endif
      default: next_addr_s = addr_q;
    endcase
  end

  // Burst FSM next state, burst context and registered outputs.
  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    addr_d        = addr_q;
    len_d         = len_q;
    size_d        = size_q;
    burst_d       = burst_q;
    cnt_d         = cnt_q;
    aw_err_d      = aw_err_q;
    err_d         = err_q;
    bid_d         = bid_q;
    bresp_d       = bresp_q;
    mem_wr_en_d   = 1'b0;
    mem_wr_addr_d = mem_wr_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_wr_strb_d = mem_wr_strb_q;

    case (state_q)
      IDLE: begin
        if (aw_hs_s) begin
          id_d     = s_axi.awid;
          addr_d   = s_axi.awaddr;
          len_d    = s_axi.awlen;
          size_d   = s_axi.awsize;
          burst_d  = s_axi.awburst;
          cnt_d    = 8'd0;
          aw_err_d = aw_err_s;
          err_d    = aw_err_s;
          state_d  = WRITE;
        end else begin
          state_d  = IDLE;
        end
      end
      WRITE: begin
        if (w_hs_s) begin
          cnt_d = cnt_q + 8'd1;
          err_d = err_next_s;
          // wlast mismatches only taint the response; the beat is still written.
          if (!aw_err_q) begin
            mem_wr_en_d   = 1'b1;
            mem_wr_addr_d = addr_q[ADDR_WIDTH-1:ADDR_LSB];
            mem_wr_data_d = s_axi.wdata;
            mem_wr_strb_d = s_axi.wstrb;
            addr_d        = next_addr_s;
          end else begin
            mem_wr_en_d   = 1'b0;
          end
          if (last_s) begin
            bid_d   = id_q;
            bresp_d = err_next_s ? 2'b10 : 2'b00;
            state_d = RESP;
          end else begin
            state_d = WRITE;
          end
        end else begin
          state_d = WRITE;
        end
      end
      RESP: begin
        if (s_axi.bready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase

    awready_d = (state_d == IDLE);
    wready_d  = (state_d == WRITE);
    bvalid_d  = (state_d == RESP);
  end

  // State and output registers; reset drops any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      id_q          <= '0;
      addr_q        <= '0;
      len_q         <= 8'd0;
      size_q        <= 3'd0;
      burst_q       <= 2'd0;
      cnt_q         <= 8'd0;
      aw_err_q      <= 1'b0;
      err_q         <= 1'b0;
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      bvalid_q      <= 1'b0;
      bid_q         <= '0;
      bresp_q       <= 2'b00;
      mem_wr_en_q   <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
      mem_wr_strb_q <= '0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      size_q        <= size_d;
      burst_q       <= burst_d;
      cnt_q         <= cnt_d;
      aw_err_q      <= aw_err_d;
      err_q         <= err_d;
      awready_q     <= awready_d;
      wready_q      <= wready_d;
      bvalid_q      <= bvalid_d;
      bid_q         <= bid_d;
      bresp_q       <= bresp_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_wr_strb_q <= mem_wr_strb_d;
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bid     = bid_q;
  assign s_axi.bresp   = bresp_q;
  assign mem_wr_en     = mem_wr_en_q;
  assign mem_wr_addr   = mem_wr_addr_q;
  assign mem_wr_data   = mem_wr_data_q;
  assign mem_wr_strb   = mem_wr_strb_q;

endmodule

// File: doc/axi_ram_wr.md
# axi_ram_wr

AXI4 write-channel slave that terminates the AW/W/B channels of an AXI4 master interface and converts each burst into a stream of single-beat, word-addressed memory write strobes. It sits directly downstream of the AXI4 master bus in the cocotbext-axi test benches. It is the write half of the RAM model that the bench's AXI master drives. It handles one burst at a time: address, then data beats, then response.

## Interface

- DATA_WIDTH, 32, AXI data width in bits (8, 16, 32, 64, 128…)
- ADDR_WIDTH, 32, AXI byte-address width
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width
- ID_WIDTH, 8, AXI ID width

- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- s_axi_awid  input  ID_WIDTH  write address ID
- s_axi_awaddr  input  ADDR_WIDTH  burst start byte address
- s_axi_awlen  input  8  beats minus one
- s_axi_awsize  input  3  log2 bytes per beat
- s_axi_awburst  input  2  burst type (00 FIXED, 01 INCR, 10 WRAP, 11 reserved)
- s_axi_awvalid  input  1  AW valid
- s_axi_awready  output  1  AW ready
- s_axi_wdata  input  DATA_WIDTH  write data
- s_axi_wstrb  input  STRB_WIDTH  byte strobes
- s_axi_wlast  input  1  last beat marker
- s_axi_wvalid  input  1  W valid
- s_axi_wready  output  1  W ready
- s_axi_bid  output  ID_WIDTH  response ID (latched awid)
- s_axi_bresp  output  2  00 OKAY, 10 SLVERR
- s_axi_bvalid  output  1  B valid
- s_axi_bready  input  1  B ready
- mem_wr_en  output  1  one-cycle write strobe per accepted beat
- mem_wr_addr  output  ADDR_WIDTH-$clog2(STRB_WIDTH)  word address (byte address >> $clog2(STRB_WIDTH))
- mem_wr_data  output  DATA_WIDTH  registered wdata
- mem_wr_strb  output  STRB_WIDTH  registered wstrb

## Operation

- FSM states: IDLE, WRITE, RESP.
- IDLE:
  - awready=1.
  - On the AW handshake, latch id, addr, len, size and burst; clear beat count and error flag; go to WRITE.
  - Error flag is set at the AW handshake if size>$clog2(STRB_WIDTH), burst=11, or (WRAP and len∉{1,3,7,15}).
- WRITE:
  - wready=1.
  - Each W handshake increments the beat count.
  - Unless errored, each W handshake writes one beat at the current address, then advances the address:
    - FIXED: unchanged.
    - INCR: addr+(1<<size), modulo 2^ADDR_WIDTH.
    - WRAP: see Configuration.
  - Burst ends on the beat where count==len, regardless of wlast; then go to RESP.
  - wlast is checked on every beat. If wlast≠(count==len), set the error flag; the beat is still written.
- RESP:
  - bvalid=1; bid=latched id; bresp=10 if error flag set, else 00.
  - On bready, go to IDLE.
- wstrb passes through unmodified; narrow-beat lane selection is the master's responsibility.
- Errored bursts consume all beats and respond SLVERR. FIXED/INCR/WRAP bursts errored at AW never assert mem_wr_en.

## Timing

- Reset values: awready=0, wready=0, bvalid=0, bresp=00, bid=0, mem_wr_en=0, mem_wr_addr/data/strb=0. awready rises the first cycle after rst deasserts.
- AW handshake in cycle N → wready=1 from N+1; awready=0 from N+1 until return to IDLE.
- W beat accepted in cycle M → mem_wr_en=1 and mem_wr_addr/data/strb valid in M+1, one-cycle pulse; back-to-back beats give continuous strobes.
- Last beat in cycle M → wready=0 and bvalid=1 in M+1.
- bvalid and bid/bresp hold stable until bready is sampled high.
- B handshake in cycle K → awready=1 in K+1. Minimum burst period is len+3 cycles.
- W beats presented before the AW handshake are not accepted (wready=0 in IDLE).
- rst asserted mid-burst: immediate return to IDLE with all outputs at reset values; the burst is dropped and no B response is issued. A pending mem_wr_en pulse is cancelled.

## Configuration

- Macro AXI_RAM_WR_WRAP_EN.
- Defined:
  - WRAP bursts with len∈{1,3,7,15} wrap within an aligned window of (len+1)<<size bytes.
  - Next address = (addr & ~mask) | ((addr+(1<<size)) & mask), where mask=((len+1)<<size)-1.
- Undefined:
  - Every WRAP burst is errored: beats consumed, no mem writes, bresp=10.
  - No wrap logic is synthesized.

## Test plan

- INCR, awaddr=0x100, len=3, size=2, DATA_WIDTH=32, 4 beats with wlast on beat 4 → mem_wr_addr 0x40,0x41,0x42,0x43, one per cycle; bresp=00; bid=awid.
- FIXED, awaddr=0x20, len=2 → three mem_wr_en pulses, all at mem_wr_addr=0x08; bresp=00.
- INCR, len=1, wlast asserted on beat 1 → two writes at consecutive words; bresp=10.
- awsize=3 on a 32-bit bus → no mem_wr_en pulses, all beats accepted, bresp=10.
- WRAP, awaddr=0x38, len=3, size=2: with AXI_RAM_WR_WRAP_EN → words 0x0E,0x0F,0x0C,0x0D, bresp=00; without it → no writes, bresp=10.
- bready held low for 5 cycles, then rst pulsed → bvalid stays high and stable until rst, then 0; awready=1 the cycle after rst deasserts.
